// File: rtl/jstk_spi_ctrl_if.sv
// rtl/jstk_spi_ctrl_if.sv - PmodJSTK SPI controller signal bundle (optional JSTK_DECODE_EN adds decoded position/button fields)
interface jstk_spi_ctrl_if;
    logic        SAMPLE;
    logic [1:0]  LED;
    logic        MISO;
    logic        SS;
    logic        SCLK;
    logic        MOSI;
    logic [39:0] DOUT;
    logic        DONE;
    logic        BUSY;
`ifdef JSTK_DECODE_EN
    logic [9:0]  X_POS;
    logic [9:0]  Y_POS;
    logic [2:0]  BTN;

    // Controller side
    modport slave (
        input  SAMPLE, LED, MISO,
        output SS, SCLK, MOSI, DOUT, DONE, BUSY, X_POS, Y_POS, BTN
    );

    // Sample source / peripheral side
    modport master (
        output SAMPLE, LED, MISO,
        input  SS, SCLK, MOSI, DOUT, DONE, BUSY, X_POS, Y_POS, BTN
    );
`else
    // Controller side
    modport slave (
        input  SAMPLE, LED, MISO,
        output SS, SCLK, MOSI, DOUT, DONE, BUSY
    );

    // Sample source / peripheral side
    modport master (
        output SAMPLE, LED, MISO,
        input  SS, SCLK, MOSI, DOUT, DONE, BUSY
    );
`endif
endinterface

// File: rtl/jstk_spi_ctrl.sv
// rtl/jstk_spi_ctrl.sv - 5-byte SPI mode-0 PmodJSTK poller started by each SAMPLE rise; JSTK_DECODE_EN adds X_POS/Y_POS/BTN
module jstk_spi_ctrl #(
    parameter int SCLK_HALF = 750,
    parameter int SS_SETUP  = 1500,
    parameter int BYTE_GAP  = 1000
) (
    input  logic CLK,
    input  logic RST,
    jstk_spi_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SS_WAIT,
        SHIFT,
        GAP,
        FINISH
    } state_t;

    // Counters are 12 bits so the largest legal SS_SETUP/BYTE_GAP fit without wrap.
    localparam logic [11:0] HALF_LAST  = 12'(SCLK_HALF - 1);
    localparam logic [11:0] SETUP_LAST = 12'(SS_SETUP - 1);
    localparam logic [11:0] GAP_LAST   = 12'(BYTE_GAP - 1);

    state_t      state;
    logic [11:0] cnt;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic        sclk_high;
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic [31:0] byte_buf;
    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        sample_rise;

    assign sample_rise = sync2 & ~sync3;

    // Bring the slow SAMPLE level into the CLK domain and keep one delayed copy for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.SAMPLE;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Transaction sequencer; every SPI pin and result is a register so nothing glitches.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            sclk_high <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            byte_buf  <= '0;
            bus.SS    <= 1'b1;
            bus.SCLK  <= 1'b0;
            bus.MOSI  <= 1'b0;
            bus.DOUT  <= '0;
            bus.DONE  <= 1'b0;
            bus.BUSY  <= 1'b0;
`ifdef JSTK_DECODE_EN
            bus.X_POS <= '0;
            bus.Y_POS <= '0;
            bus.BTN   <= '0;
`endif
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_rise) begin
                        tx        <= {6'b100000, bus.LED};
                        byte_idx  <= '0;
                        bit_idx   <= '0;
                        cnt       <= '0;
                        sclk_high <= 1'b0;
                        bus.SS    <= 1'b0;
                        bus.BUSY  <= 1'b1;
                        bus.SCLK  <= 1'b0;
                        bus.MOSI  <= 1'b1;
                        state     <= SS_WAIT;
                    end
                end

                SS_WAIT: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end

                SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 12'd1;
                    end else if (!sclk_high) begin
                        // Low half done: raise SCLK and capture MISO on the same edge.
                        cnt       <= '0;
                        sclk_high <= 1'b1;
                        bus.SCLK  <= 1'b1;
                        rx        <= {rx[6:0], bus.MISO};
                    end else begin
                        // High half done: drop SCLK and present the next MOSI bit.
                        cnt       <= '0;
                        sclk_high <= 1'b0;
                        bus.SCLK  <= 1'b0;
                        if (bit_idx != 3'd7) begin
                            bit_idx  <= bit_idx + 3'd1;
                            tx       <= {tx[6:0], 1'b0};
                            bus.MOSI <= tx[6];
                        end else if (byte_idx < 3'd4) begin
                            bit_idx  <= '0;
                            byte_buf <= {byte_buf[23:0], rx};
                            byte_idx <= byte_idx + 3'd1;
                            tx       <= 8'h00;
                            bus.MOSI <= 1'b0;
                            state    <= GAP;
                        end else begin
                            // Last byte: publish the whole result at once as SS rises.
                            bit_idx  <= '0;
                            bus.SS   <= 1'b1;
                            bus.MOSI <= 1'b0;
                            bus.DONE <= 1'b1;
                            bus.DOUT <= {byte_buf, rx};
`ifdef JSTK_DECODE_EN
                            bus.X_POS <= {byte_buf[17:16], byte_buf[31:24]};
                            bus.Y_POS <= {byte_buf[1:0], byte_buf[15:8]};
                            bus.BTN   <= rx[2:0];
`endif
                            state    <= FINISH;
                        end
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end

                FINISH: begin
                    // A sample edge landing here is deliberately ignored.
                    bus.BUSY <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_spi_ctrl.sv
// tb/tb_jstk_spi_ctrl.sv - self-checking bench for jstk_spi_ctrl with a byte-level PmodJSTK slave model
module tb_jstk_spi_ctrl;

    localparam int SCLK_HALF = 2;
    localparam int SS_SETUP  = 4;
    localparam int BYTE_GAP  = 3;
    localparam int SS_LOW    = SS_SETUP + 5*16*SCLK_HALF + 4*BYTE_GAP;

    logic CLK = 1'b0;
    logic RST;

    jstk_spi_ctrl_if bus ();

    jstk_spi_ctrl #(
        .SCLK_HALF(SCLK_HALF),
        .SS_SETUP (SS_SETUP),
        .BYTE_GAP (BYTE_GAP)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Slave model and bus observer
    logic [39:0] slave_data = '0;
    logic [39:0] mosi_stream = '0;
    logic [39:0] dout_prev = '0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b0;
    int          rises = 0;
    int          ss_low = 0;
    int          low_run = 0;
    int          done_count = 0;
    int          dout_glitch = 0;
    int          gap_len [4];

    always @(negedge CLK) begin
        if (!RST && bus.DOUT !== dout_prev && !bus.DONE)
            dout_glitch <= dout_glitch + 1;
        dout_prev <= bus.DOUT;
        if (bus.DONE === 1'b1)
            done_count <= done_count + 1;
        ss_prev   <= bus.SS;
        sclk_prev <= bus.SCLK;
        if (bus.SS !== 1'b0) begin
            bus.MISO <= 1'b0;
        end else if (ss_prev) begin
            rises       <= 0;
            ss_low      <= 1;
            low_run     <= 1;
            mosi_stream <= '0;
            bus.MISO    <= slave_data[39];
        end else begin
            ss_low <= ss_low + 1;
            if (bus.SCLK && !sclk_prev) begin
                rises       <= rises + 1;
                mosi_stream <= {mosi_stream[38:0], bus.MOSI};
                if (rises % 8 == 0 && rises > 0 && rises < 40)
                    gap_len[rises/8 - 1] <= low_run;
                low_run <= 0;
            end else if (!bus.SCLK) begin
                low_run <= low_run + 1;
                if (rises >= 40)
                    bus.MISO <= 1'b0;
                else if (rises % 8 == 0 && rises > 0 && low_run + 1 <= BYTE_GAP)
                    bus.MISO <= 1'($urandom);
                else
                    bus.MISO <= slave_data[39 - rises];
            end
        end
    end

    typedef struct {
        logic [1:0] led;
        logic [7:0] b [5];
        logic [39:0] exp_dout;
        int          mode;
    } vec_t;

    vec_t vecs [8];

    // Reference: bytes arrive in order, first byte lands in the top of DOUT.
    function automatic logic [39:0] model_dout(input logic [7:0] b [5]);
        logic [39:0] r = '0;
        for (int i = 0; i < 5; i++) r = (r << 8) | 40'(b[i]);
        return r;
    endfunction

    // mode 0: plain, 1: extra SAMPLE edge mid-transaction, 2: edge lands in the DONE cycle
    task automatic run_txn(input vec_t v);
        int n;
        int dc0;
        int ss_extra;
        bus.SAMPLE = 1'b0;
        repeat (4) tick();
        slave_data = model_dout(v.b);
        dc0 = done_count;
        bus.LED    = v.led;
        bus.SAMPLE = 1'b1;
        n = 0;
        while (bus.SS !== 1'b0 && n < 10) begin tick(); n++; end
        check("ss_fall_latency", 64'(n), 64'd3);
        check("busy_with_ss", 64'(bus.BUSY), 64'd1);
        n = 1;
        while (bus.DONE !== 1'b1 && n < 2000) begin
            tick();
            n++;
            if (v.mode == 1 && n == 60) bus.SAMPLE = 1'b0;
            if (v.mode == 1 && n == 70) bus.SAMPLE = 1'b1;
            if (v.mode == 2 && n == 10) bus.SAMPLE = 1'b0;
            if (v.mode == 2 && n == SS_LOW - 1) bus.SAMPLE = 1'b1;
        end
        check("done_cycle", 64'(n), 64'(SS_LOW + 1));
        check("done_ss_high", 64'(bus.SS), 64'd1);
        check("done_busy", 64'(bus.BUSY), 64'd1);
        check("done_sclk", 64'(bus.SCLK), 64'd0);
        check("done_mosi", 64'(bus.MOSI), 64'd0);
        check("dout", 64'(bus.DOUT), 64'(v.exp_dout));
`ifdef JSTK_DECODE_EN
        check("x_pos", 64'(bus.X_POS), 64'({v.b[1][1:0], v.b[0]}));
        check("y_pos", 64'(bus.Y_POS), 64'({v.b[3][1:0], v.b[2]}));
        check("btn", 64'(bus.BTN), 64'(v.b[4][2:0]));
`endif
        check("sclk_rises", 64'(rises), 64'd40);
        check("mosi_stream", 64'(mosi_stream), {24'h0, 6'b100000, v.led, 32'h0});
        check("ss_low_len", 64'(ss_low), 64'(SS_LOW));
        for (int g = 0; g < 4; g++)
            check("byte_gap_low", 64'(gap_len[g]), 64'(BYTE_GAP + SCLK_HALF));
        tick();
        check("busy_drop", 64'(bus.BUSY), 64'd0);
        check("done_pulse_width", 64'(bus.DONE), 64'd0);
        check("done_count", 64'(done_count), 64'(dc0 + 1));
        ss_extra = 0;
        repeat (30) begin tick(); if (bus.SS !== 1'b1) ss_extra++; end
        check("no_extra_txn", 64'(ss_extra), 64'd0);
        check("dout_stable", 64'(dout_glitch), 64'd0);
    endtask

    task automatic reset_mid_shift();
        int n;
        int dc0;
        int ss_extra;
        bus.SAMPLE = 1'b0;
        repeat (4) tick();
        bus.SAMPLE = 1'b1;
        n = 0;
        while (bus.SS !== 1'b0 && n < 10) begin tick(); n++; end
        check("rst_txn_start", 64'(bus.SS), 64'd0);
        repeat (20) tick();
        RST = 1'b1;
        #1;
        check("rst_ss", 64'(bus.SS), 64'd1);
        check("rst_sclk", 64'(bus.SCLK), 64'd0);
        check("rst_mosi", 64'(bus.MOSI), 64'd0);
        check("rst_busy", 64'(bus.BUSY), 64'd0);
        check("rst_dout", 64'(bus.DOUT), 64'd0);
        check("rst_done", 64'(bus.DONE), 64'd0);
        bus.SAMPLE = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        dc0 = done_count;
        ss_extra = 0;
        repeat (300) begin tick(); if (bus.SS !== 1'b1) ss_extra++; end
        check("rst_no_done", 64'(done_count), 64'(dc0));
        check("rst_no_txn", 64'(ss_extra), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        bus.SAMPLE = 1'b0;
        bus.LED    = 2'b00;
        repeat (3) tick();
        check("reset_ss", 64'(bus.SS), 64'd1);
        check("reset_sclk", 64'(bus.SCLK), 64'd0);
        check("reset_mosi", 64'(bus.MOSI), 64'd0);
        check("reset_dout", 64'(bus.DOUT), 64'd0);
        check("reset_done", 64'(bus.DONE), 64'd0);
        check("reset_busy", 64'(bus.BUSY), 64'd0);
`ifdef JSTK_DECODE_EN
        check("reset_x", 64'(bus.X_POS), 64'd0);
        check("reset_y", 64'(bus.Y_POS), 64'd0);
        check("reset_btn", 64'(bus.BTN), 64'd0);
`endif
        RST = 1'b0;
        tick();

        vecs[0].led = 2'b01;
        vecs[0].b   = '{8'hC3, 8'h02, 8'h5A, 8'h01, 8'h05};
        vecs[0].exp_dout = 40'hC3025A0105;
        vecs[0].mode = 0;
        for (int i = 1; i < 8; i++) begin
            vecs[i].led = 2'($urandom_range(0, 3));
            for (int k = 0; k < 5; k++) vecs[i].b[k] = 8'($urandom);
            vecs[i].exp_dout = model_dout(vecs[i].b);
            vecs[i].mode = (i == 1) ? 1 : (i == 2) ? 2 : 0;
        end

        run_txn(vecs[0]);
        reset_mid_shift();
        for (int i = 1; i < 8; i++) run_txn(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jstk_spi_ctrl.md
Name: jstk_spi_ctrl

Overview:
Downstream consumer of the 5 Hz divided clock in the joystick design. Each rising edge of the 5 Hz sample clock starts one 5-byte SPI mode-0 transaction with the PmodJSTK on the Nexys 4 DDR. The block drives the LED command byte and captures the returned X, Y and button bytes. It presents a 40-bit result with a one-cycle DONE strobe to the display/application logic.

Parameters:
SCLK_HALF, 750, CLK cycles per SCLK half-period (100 MHz / 1500 = 66.67 kHz); legal range 1..1023
SS_SETUP, 1500, CLK cycles from SS falling to first SCLK rise window (15 us); legal range 1..4095
BYTE_GAP, 1000, CLK cycles of SCLK-low idle between bytes (10 us); legal range 1..4095

Ports:
CLK  input  1  system clock, 100 MHz
RST  input  1  reset, asynchronous, active-high
SAMPLE  input  1  5 Hz clock level from divider; each rising edge requests one transaction
LED  input  2  LED command bits, sampled at transaction start
MISO  input  1  SPI data from PmodJSTK
SS  output  1  SPI slave select, active-low
SCLK  output  1  SPI clock, idle low
MOSI  output  1  SPI data to PmodJSTK
DOUT  output  40  last completed transaction; [39:32] = first byte received
DONE  output  1  one-cycle pulse when DOUT updates
BUSY  output  1  high from SS falling until DONE cycle inclusive

Behaviour:
- Reset values: SS=1, SCLK=0, MOSI=0, DOUT=0, DONE=0, BUSY=0, FSM=IDLE. Synchroniser flops clear to 0.
- SAMPLE passes through a 2-flop synchroniser and then a rising-edge detect. SS falls on the 3rd CLK edge after SAMPLE rises; BUSY rises on the same edge.
- FSM states: IDLE -> SS_WAIT -> SHIFT -> (GAP -> SHIFT)x4 -> FINISH -> IDLE.
- IDLE: on a detected edge, latch LED, load TX byte {6'b100000, LED}, clear the byte index, and go to SS_WAIT.
- SS_WAIT: hold SCLK=0 and MOSI=TX[7] for SS_SETUP cycles, then go to SHIFT.
- SHIFT: 8 bits, MSB first. For each bit, SCLK is low for SCLK_HALF cycles, then high for SCLK_HALF cycles.
  - MISO is shifted into RX on the CLK edge that drives SCLK high.
  - MOSI updates to the next bit on the edge that drives SCLK low.
  - After the 8th high phase, SCLK returns low.
  - If byte index < 4: store RX into the byte buffer, increment the index, load TX=8'h00, and go to GAP.
  - If byte index = 4: go to FINISH.
- GAP: SCLK=0 and MOSI=TX[7] for BYTE_GAP cycles, then go to SHIFT.
- FINISH: in one cycle, SS=1, DOUT={b0,b1,b2,b3,b4}, DONE=1, and MOSI=0. BUSY is still high in this cycle and drops on the next. Next state is IDLE.
- SAMPLE edges detected while BUSY are dropped, not queued. A sample edge exactly in the FINISH cycle is also dropped.
- DOUT holds between transactions and changes only in the DONE cycle. It is never partially updated.
- Asserting RST mid-transaction immediately forces all reset values, including DOUT=0. SS rises asynchronously. No DONE is produced for the aborted transaction.
- Counters are sized for the maximum parameter values and reload to 0 on each state entry. There is no wrap-around within a state.
- Total SS-low duration = SS_SETUP + 5*16*SCLK_HALF + 4*BYTE_GAP cycles.

Optional Feature:
JSTK_DECODE_EN
- Defined: adds outputs X_POS[9:0], Y_POS[9:0] and BTN[2:0], registered in the DONE cycle and reset to 0.
  - X_POS = {b1[1:0], b0}.
  - Y_POS = {b3[1:0], b2}.
  - BTN = b4[2:0].
- Undefined: these ports and registers are absent. DOUT is the only result.

Test Plan:
All scenarios use SCLK_HALF=2, SS_SETUP=4, BYTE_GAP=3.
- Reset: assert RST mid-SHIFT -> SS=1, SCLK=0, MOSI=0, BUSY=0, DOUT=0 in the same cycle. After RST is released, no DONE without a new SAMPLE edge.
- Transaction framing: LED=2'b01, SAMPLE rises -> SS falls 3 CLK later. MOSI bits are 1,0,0,0,0,0,0,1 on byte 0 and all zeros on bytes 1-4. Exactly 40 SCLK rises. SS stays low 4+80*2+12=176 cycles.
- Capture: model slave returns 8'hC3,8'h02,8'h5A,8'h01,8'h05 -> DOUT=40'hC3025A0105 and a single DONE pulse in the SS-rise cycle. With JSTK_DECODE_EN: X_POS=10'h2C3, Y_POS=10'h15A, BTN=3'b101.
- Overlap: second SAMPLE rising edge while BUSY -> ignored. Exactly one DONE, and DOUT is unchanged until that DONE.
- Back-to-back: two transactions with different slave data -> DOUT holds the first value until the second DONE, then updates atomically. BUSY is low for at least 1 cycle between them.
- Byte gap: measure SCLK-low time between bytes -> BYTE_GAP + SCLK_HALF cycles = 5. MISO changing during the gap has no effect on RX.
